// File: rtl/pipe5_types_pkg.sv
// Shared types and constants for the pipe5 hazard/forwarding control slice.
package pipe5_types_pkg;

  typedef enum logic [1:0] {
    BYPASS_NONE = 2'd0,
    BYPASS_M    = 2'd1,
    BYPASS_W    = 2'd2
  } bypass_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TRAP   = 2'd2,
    ST_HALTED = 2'd3
  } hazard_state_t;

  localparam logic [3:0] CAUSE_MAL_INSN   = 4'd0;
  localparam logic [3:0] CAUSE_FAULT_INSN = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_MAL_LD     = 4'd4;
  localparam logic [3:0] CAUSE_FAULT_LD   = 4'd5;
  localparam logic [3:0] CAUSE_MAL_ST     = 4'd6;
  localparam logic [3:0] CAUSE_FAULT_ST   = 4'd7;
  localparam logic [3:0] CAUSE_ENV_M      = 4'd11;

  // x0 is hardwired, so a write to it never produces forwardable data.
  function automatic logic reg_hit(input logic [4:0] rs, input logic [4:0] rd, input logic wen);
    return wen && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/pipe5_bypass_select.sv
// Forwarding select for one source operand: the younger M-stage result beats W.
module pipe5_bypass_select
  import pipe5_types_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       wen_m,
  input  logic       wen_w,
  input  logic       dren,
  output bypass_t    sel
);

  // A load in M has no data yet, so it can only be covered by the load-use stall.
  always_comb begin
    sel = BYPASS_NONE;
    if (reg_hit(rs, rd_m, wen_m) && !dren) begin
      sel = BYPASS_M;
    end else if (reg_hit(rs, rd_w, wen_w)) begin
      sel = BYPASS_W;
    end else begin
      sel = BYPASS_NONE;
    end
  end

endmodule

// File: rtl/pipe5_hazard_control.sv
// Pipe5 hazard control: stall/flush arbitration, forwarding selects, trap sequencing
// (drain memory, then redirect) and a stall performance counter.
module pipe5_hazard_control
  import pipe5_types_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              f_busy,
  input  logic              x_busy,
  input  logic              m_busy,
  input  logic              dren,
  input  logic              dwen,
  input  logic              fence_stall,
  input  logic              jump,
  input  logic              mispredict,
  input  logic              halt,
  input  logic              ret,
  input  logic              fault_insn,
  input  logic              mal_insn,
  input  logic              illegal_insn,
  input  logic              fault_ld,
  input  logic              mal_ld,
  input  logic              fault_st,
  input  logic              mal_st,
  input  logic              breakpoint,
  input  logic              env_m,
  input  logic [31:0]       epc_f,
  input  logic [31:0]       epc_m,
  input  logic [31:0]       badaddr_f,
  input  logic [31:0]       badaddr_m,
  input  logic [31:0]       trap_vector,
  input  logic [4:0]        rs1_x,
  input  logic [4:0]        rs2_x,
  input  logic [4:0]        rd_m,
  input  logic [4:0]        rd_w,
  input  logic              regWEN_m,
  input  logic              regWEN_w,
  output logic              pc_en,
  output logic              npc_sel,
  output logic              iren,
  output logic              fd_stall,
  output logic              dx_stall,
  output logic              xm_stall,
  output logic              mw_stall,
  output logic              fd_flush,
  output logic              dx_flush,
  output logic              xm_flush,
  output logic              mw_flush,
  output logic              insert_priv_pc,
  output logic [31:0]       priv_pc,
  output bypass_t           bypass_a,
  output bypass_t           bypass_b,
  output bypass_t           bypass_rs1,
  output bypass_t           bypass_rs2,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_epc,
  output logic [31:0]       exc_badaddr,
  output logic [PERF_W-1:0] stall_cycles
);

  hazard_state_t     state_r, state_nxt_s;
  bypass_t           byp1_s, byp2_s;
  logic              load_use_s;
  logic              exc_any_s;
  logic [3:0]        exc_cause_s;
  logic [31:0]       exc_epc_s, exc_bad_s;
  logic              pc_en_s, npc_sel_s, iren_s, insert_s;
  logic [3:0]        stall_s, flush_s;
  logic              ret_r;
  logic [3:0]        exc_cause_r;
  logic [31:0]       exc_epc_r, exc_bad_r, priv_pc_r;
  logic [PERF_W-1:0] stall_cycles_r;
  logic              unused_s;

  // Store completion is already reflected in m_busy, so dwen carries no hazard here.
  assign unused_s = dwen;

  pipe5_bypass_select u_byp_rs1 (
    .rs(rs1_x), .rd_m(rd_m), .rd_w(rd_w), .wen_m(regWEN_m), .wen_w(regWEN_w),
    .dren(dren), .sel(byp1_s)
  );

  pipe5_bypass_select u_byp_rs2 (
    .rs(rs2_x), .rd_m(rd_m), .rd_w(rd_w), .wen_m(regWEN_m), .wen_w(regWEN_w),
    .dren(dren), .sel(byp2_s)
  );

  assign load_use_s = dren && regWEN_m && (rd_m != 5'd0) && ((rd_m == rs1_x) || (rd_m == rs2_x));

  // Exception source priority: M-stage sources first, then fetch-side sources.
  always_comb begin
    exc_any_s   = 1'b1;
    exc_cause_s = CAUSE_MAL_INSN;
    exc_epc_s   = epc_m;
    exc_bad_s   = badaddr_m;
    if (illegal_insn) begin
      exc_cause_s = CAUSE_ILLEGAL;
    end else if (breakpoint) begin
      exc_cause_s = CAUSE_BREAKPOINT;
    end else if (env_m) begin
      exc_cause_s = CAUSE_ENV_M;
    end else if (mal_ld) begin
      exc_cause_s = CAUSE_MAL_LD;
    end else if (fault_ld) begin
      exc_cause_s = CAUSE_FAULT_LD;
    end else if (mal_st) begin
      exc_cause_s = CAUSE_MAL_ST;
    end else if (fault_st) begin
      exc_cause_s = CAUSE_FAULT_ST;
    end else if (fault_insn) begin
      exc_cause_s = CAUSE_FAULT_INSN;
      exc_epc_s   = epc_f;
      exc_bad_s   = badaddr_f;
    end else if (mal_insn) begin
      exc_cause_s = CAUSE_MAL_INSN;
      exc_epc_s   = epc_f;
      exc_bad_s   = badaddr_f;
    end else begin
      exc_any_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a trap or ret outranks halt; traps wait for memory to go idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (exc_any_s || ret) begin
          state_nxt_s = m_busy ? ST_DRAIN : ST_TRAP;
        end else if (halt) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN:  state_nxt_s = m_busy ? ST_DRAIN : ST_TRAP;
      ST_TRAP:   state_nxt_s = ST_RUN;
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // Pipeline control per state; bit order of stall_s/flush_s is {fd, dx, xm, mw}.
  always_comb begin
    pc_en_s   = 1'b0;
    npc_sel_s = 1'b0;
    iren_s    = 1'b1;
    insert_s  = 1'b0;
    stall_s   = 4'b0000;
    flush_s   = 4'b0000;
    case (state_r)
      ST_RUN: begin
        if (m_busy || fence_stall) begin
          stall_s = 4'b1110;
          flush_s = 4'b0001;
        end else if (mispredict || jump) begin
          npc_sel_s = 1'b1;
          pc_en_s   = 1'b1;
          flush_s   = 4'b1110;
        end else if (load_use_s || x_busy) begin
          stall_s = 4'b1100;
          flush_s = 4'b0010;
        end else if (f_busy) begin
          flush_s = 4'b1000;
        end else begin
          pc_en_s = 1'b1;
        end
      end
      ST_DRAIN: stall_s = 4'b1111;
      ST_TRAP: begin
        insert_s = 1'b1;
        pc_en_s  = 1'b1;
        flush_s  = 4'b1111;
      end
      ST_HALTED: begin
        iren_s  = 1'b0;
        stall_s = 4'b1111;
      end
      default: begin
        stall_s = 4'b0000;
        flush_s = 4'b1111;
      end
    endcase
  end

  // Trap context: cause/epc/badaddr latch on detection, the redirect target on TRAP entry.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      exc_cause_r <= 4'd0;
      exc_epc_r   <= 32'd0;
      exc_bad_r   <= 32'd0;
      ret_r       <= 1'b0;
      priv_pc_r   <= 32'd0;
    end else begin
      if ((state_r == ST_RUN) && exc_any_s) begin
        exc_cause_r <= exc_cause_s;
        exc_epc_r   <= exc_epc_s;
        exc_bad_r   <= exc_bad_s;
        ret_r       <= 1'b0;
      end else if ((state_r == ST_RUN) && ret) begin
        ret_r <= 1'b1;
      end
      if (state_nxt_s == ST_TRAP) begin
        priv_pc_r <= trap_vector;
      end
    end
  end

  // Stall performance counter, wraps naturally.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (fd_stall) begin
      stall_cycles_r <= stall_cycles_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset holds the pipe flushed with fetch disabled.
  assign pc_en          = nRST & pc_en_s;
  assign npc_sel        = nRST & npc_sel_s;
  assign iren           = nRST & iren_s;
  assign insert_priv_pc = nRST & insert_s;
  assign fd_stall       = nRST & stall_s[3];
  assign dx_stall       = nRST & stall_s[2];
  assign xm_stall       = nRST & stall_s[1];
  assign mw_stall       = nRST & stall_s[0];
  assign fd_flush       = ~nRST | flush_s[3];
  assign dx_flush       = ~nRST | flush_s[2];
  assign xm_flush       = ~nRST | flush_s[1];
  assign mw_flush       = ~nRST | flush_s[0];
  assign bypass_rs1     = nRST ? byp1_s : BYPASS_NONE;
  assign bypass_rs2     = nRST ? byp2_s : BYPASS_NONE;
  assign bypass_a       = bypass_rs1;
  assign bypass_b       = bypass_rs2;
  assign exc_valid      = nRST & (state_r == ST_TRAP) & ~ret_r;
  assign exc_cause      = exc_cause_r;
  assign exc_epc        = exc_epc_r;
  assign exc_badaddr    = exc_bad_r;
  assign priv_pc        = priv_pc_r;
  assign stall_cycles   = stall_cycles_r;

endmodule

// File: tb/tb_pipe5_hazard_control.sv
// Self-checking bench for pipe5_hazard_control: forwarding table, trap/halt sequences, random run vs model.
module tb_pipe5_hazard_control;
  import pipe5_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  logic f_busy, x_busy, m_busy, dren, dwen, fence_stall, jump, mispredict, halt, ret;
  logic fault_insn, mal_insn, illegal_insn, fault_ld, mal_ld, fault_st, mal_st, breakpoint, env_m;
  logic [31:0] epc_f, epc_m, badaddr_f, badaddr_m, trap_vector;
  logic [4:0] rs1_x, rs2_x, rd_m, rd_w;
  logic regWEN_m, regWEN_w;
  logic pc_en, npc_sel, iren, fd_stall, dx_stall, xm_stall, mw_stall;
  logic fd_flush, dx_flush, xm_flush, mw_flush, insert_priv_pc, exc_valid;
  logic [31:0] priv_pc, exc_epc, exc_badaddr, stall_cycles;
  logic [3:0] exc_cause;
  bypass_t bypass_a, bypass_b, bypass_rs1, bypass_rs2;

  pipe5_hazard_control #(.PERF_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .f_busy(f_busy), .x_busy(x_busy), .m_busy(m_busy),
    .dren(dren), .dwen(dwen), .fence_stall(fence_stall), .jump(jump), .mispredict(mispredict),
    .halt(halt), .ret(ret), .fault_insn(fault_insn), .mal_insn(mal_insn),
    .illegal_insn(illegal_insn), .fault_ld(fault_ld), .mal_ld(mal_ld), .fault_st(fault_st),
    .mal_st(mal_st), .breakpoint(breakpoint), .env_m(env_m), .epc_f(epc_f), .epc_m(epc_m),
    .badaddr_f(badaddr_f), .badaddr_m(badaddr_m), .trap_vector(trap_vector),
    .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_m(rd_m), .rd_w(rd_w), .regWEN_m(regWEN_m),
    .regWEN_w(regWEN_w), .pc_en(pc_en), .npc_sel(npc_sel), .iren(iren),
    .fd_stall(fd_stall), .dx_stall(dx_stall), .xm_stall(xm_stall), .mw_stall(mw_stall),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush), .mw_flush(mw_flush),
    .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc), .bypass_a(bypass_a),
    .bypass_b(bypass_b), .bypass_rs1(bypass_rs1), .bypass_rs2(bypass_rs2),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_epc(exc_epc),
    .exc_badaddr(exc_badaddr), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: pipeline mode flags plus the architecturally visible trap context.
  bit          md_halted, md_drain, md_trap, md_ret;
  logic [3:0]  md_cause;
  logic [31:0] md_epc, md_bad, md_priv, md_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic load_use();
    return dren && regWEN_m && (rd_m != 5'd0) && ((rd_m == rs1_x) || (rd_m == rs2_x));
  endfunction

  function automatic int exc_code();
    bit flags [9];
    int codes [9];
    flags = '{illegal_insn, breakpoint, env_m, mal_ld, fault_ld, mal_st, fault_st, fault_insn, mal_insn};
    codes = '{2, 3, 11, 4, 5, 6, 7, 1, 0};
    for (int i = 0; i < 9; i++) if (flags[i]) return codes[i];
    return -1;
  endfunction

  // Expected {pc_en, npc_sel, iren, insert, stall fd..mw, flush fd..mw}.
  function automatic logic [11:0] exp_ctrl();
    logic pc, ns, ir, ins;
    logic [3:0] st, fl;
    pc = 1'b0; ns = 1'b0; ir = 1'b1; ins = 1'b0; st = 4'h0; fl = 4'h0;
    if (!nRST) begin fl = 4'hF; ir = 1'b0; end
    else if (md_halted) begin ir = 1'b0; st = 4'hF; end
    else if (md_trap) begin ins = 1'b1; pc = 1'b1; fl = 4'hF; end
    else if (md_drain) st = 4'hF;
    else if (m_busy || fence_stall) begin st = 4'b1110; fl = 4'b0001; end
    else if (mispredict || jump) begin ns = 1'b1; pc = 1'b1; fl = 4'b1110; end
    else if (load_use() || x_busy) begin st = 4'b1100; fl = 4'b0010; end
    else if (f_busy) fl = 4'b1000;
    else pc = 1'b1;
    return {pc, ns, ir, ins, st, fl};
  endfunction

  function automatic bypass_t exp_byp(input logic [4:0] rs);
    if (!nRST || rs == 5'd0) return BYPASS_NONE;
    if (regWEN_m && rd_m == rs && !dren) return BYPASS_M;
    if (regWEN_w && rd_w == rs) return BYPASS_W;
    return BYPASS_NONE;
  endfunction

  task automatic model_step();
    logic [11:0] c;
    int code;
    c = exp_ctrl();
    code = exc_code();
    if (!nRST) begin
      md_halted = 1'b0; md_drain = 1'b0; md_trap = 1'b0; md_ret = 1'b0;
      md_cause = 4'd0; md_epc = 32'd0; md_bad = 32'd0; md_priv = 32'd0; md_cnt = 32'd0;
      return;
    end
    if (c[7]) md_cnt = md_cnt + 32'd1;
    if (md_trap) md_trap = 1'b0;
    else if (md_drain) begin
      if (!m_busy) begin md_drain = 1'b0; md_trap = 1'b1; md_priv = trap_vector; end
    end else if (!md_halted) begin
      if (code >= 0 || ret) begin
        if (code >= 0) begin
          md_cause = 4'(code);
          md_epc = (code <= 1) ? epc_f : epc_m;
          md_bad = (code <= 1) ? badaddr_f : badaddr_m;
          md_ret = 1'b0;
        end else md_ret = 1'b1;
        if (m_busy) md_drain = 1'b1;
        else begin md_trap = 1'b1; md_priv = trap_vector; end
      end else if (halt) md_halted = 1'b1;
    end
  endtask

  task automatic at_neg(input string tag);
    logic [11:0] c;
    @(negedge CLK);
    c = exp_ctrl();
    check({tag, ".ctrl"}, 32'({pc_en, npc_sel, iren, insert_priv_pc, fd_stall, dx_stall, xm_stall,
                                mw_stall, fd_flush, dx_flush, xm_flush, mw_flush}), 32'(c));
    check({tag, ".byp_rs1"}, 32'(bypass_rs1), 32'(exp_byp(rs1_x)));
    check({tag, ".byp_rs2"}, 32'(bypass_rs2), 32'(exp_byp(rs2_x)));
    check({tag, ".byp_a"}, 32'(bypass_a), 32'(exp_byp(rs1_x)));
    check({tag, ".byp_b"}, 32'(bypass_b), 32'(exp_byp(rs2_x)));
    check({tag, ".exc_valid"}, 32'(exc_valid), 32'(nRST && md_trap && !md_ret));
    check({tag, ".exc_cause"}, 32'(exc_cause), 32'(md_cause));
    check({tag, ".exc_epc"}, exc_epc, md_epc);
    check({tag, ".exc_badaddr"}, exc_badaddr, md_bad);
    check({tag, ".priv_pc"}, priv_pc, md_priv);
    check({tag, ".stall_cycles"}, stall_cycles, md_cnt);
  endtask

  task automatic edge_step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    {f_busy, x_busy, m_busy, dren, dwen, fence_stall, jump, mispredict, halt, ret} = 10'd0;
    {fault_insn, mal_insn, illegal_insn, fault_ld, mal_ld, fault_st, mal_st, breakpoint, env_m} = 9'd0;
    epc_f = 32'h0000_0100; epc_m = 32'h0000_0200; badaddr_f = 32'h0000_0300; badaddr_m = 32'h0000_0400;
    trap_vector = 32'h8000_0000;
    rs1_x = 5'd0; rs2_x = 5'd0; rd_m = 5'd0; rd_w = 5'd0; regWEN_m = 1'b0; regWEN_w = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rdm, rdw;
    logic       wm, ww, dr;
    bypass_t    e1, e2;
    logic       e_pc_en;
  } fwd_vec_t;

  fwd_vec_t fwd_tab [10];

  initial begin
    fwd_tab[0] = '{5'd5,  5'd0,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, BYPASS_M,    BYPASS_NONE, 1'b1};
    fwd_tab[1] = '{5'd5,  5'd0,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, BYPASS_M,    BYPASS_NONE, 1'b1};
    fwd_tab[2] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, BYPASS_NONE, BYPASS_NONE, 1'b1};
    fwd_tab[3] = '{5'd3,  5'd9,  5'd4,  5'd9,  1'b1, 1'b1, 1'b0, BYPASS_NONE, BYPASS_W,    1'b1};
    fwd_tab[4] = '{5'd6,  5'd6,  5'd6,  5'd6,  1'b0, 1'b1, 1'b0, BYPASS_W,    BYPASS_W,    1'b1};
    fwd_tab[5] = '{5'd1,  5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b1, BYPASS_NONE, BYPASS_W,    1'b0};
    fwd_tab[6] = '{5'd0,  5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b1, BYPASS_NONE, BYPASS_NONE, 1'b0};
    fwd_tab[7] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, BYPASS_NONE, BYPASS_NONE, 1'b1};
    fwd_tab[8] = '{5'd7,  5'd0,  5'd7,  5'd0,  1'b0, 1'b0, 1'b1, BYPASS_NONE, BYPASS_NONE, 1'b1};
    fwd_tab[9] = '{5'd31, 5'd31, 5'd31, 5'd0,  1'b1, 1'b0, 1'b0, BYPASS_M,    BYPASS_M,    1'b1};

    clear_inputs();
    nRST = 1'b0;
    edge_step();
    at_neg("reset");
    check("reset.pc_en", 32'(pc_en), 32'd0);
    check("reset.flush", 32'({fd_flush, dx_flush, xm_flush, mw_flush}), 32'hF);
    check("reset.stall_cycles", stall_cycles, 32'd0);
    edge_step();
    nRST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      rs1_x = fwd_tab[i].rs1; rs2_x = fwd_tab[i].rs2; rd_m = fwd_tab[i].rdm; rd_w = fwd_tab[i].rdw;
      regWEN_m = fwd_tab[i].wm; regWEN_w = fwd_tab[i].ww; dren = fwd_tab[i].dr;
      at_neg("fwd");
      check($sformatf("tab%0d.rs1", i), 32'(bypass_rs1), 32'(fwd_tab[i].e1));
      check($sformatf("tab%0d.rs2", i), 32'(bypass_rs2), 32'(fwd_tab[i].e2));
      check($sformatf("tab%0d.pc_en", i), 32'(pc_en), 32'(fwd_tab[i].e_pc_en));
      check($sformatf("tab%0d.lu", i), 32'({fd_stall, dx_stall, xm_flush}), 32'({3{~fwd_tab[i].e_pc_en}}));
      edge_step();
    end

    // fault_ld while memory is busy for three cycles: drain, then one redirect cycle
    clear_inputs();
    fault_ld = 1'b1; m_busy = 1'b1; epc_m = 32'h1000_0040; badaddr_m = 32'hDEAD_0004;
    at_neg("drain_entry");
    edge_step();
    fault_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_busy = (i < 2);
      at_neg("drain");
      check($sformatf("drain%0d.stall", i), 32'({fd_stall, dx_stall, xm_stall, mw_stall, pc_en}), 32'h1E);
      edge_step();
    end
    m_busy = 1'b0;
    at_neg("trap");
    check("trap.insert", 32'(insert_priv_pc), 32'd1);
    check("trap.flush", 32'({fd_flush, dx_flush, xm_flush, mw_flush}), 32'hF);
    check("trap.cause", 32'(exc_cause), 32'd5);
    check("trap.epc", exc_epc, 32'h1000_0040);
    check("trap.valid", 32'(exc_valid), 32'd1);
    check("trap.priv_pc", priv_pc, 32'h8000_0000);
    edge_step();
    at_neg("post_trap");
    check("post_trap.insert", 32'(insert_priv_pc), 32'd0);

    // mispredict outranks x_busy
    mispredict = 1'b1; x_busy = 1'b1;
    at_neg("mispredict");
    check("mispredict.sel", 32'({npc_sel, fd_flush, dx_flush, xm_flush}), 32'hF);
    check("mispredict.stall", 32'({fd_stall, dx_stall, xm_stall}), 32'd0);
    edge_step();

    // fetch fault and illegal instruction together: the M-side source wins
    clear_inputs();
    fault_insn = 1'b1; illegal_insn = 1'b1; epc_f = 32'h0000_1110; epc_m = 32'h0000_2220;
    at_neg("dual_exc");
    edge_step();
    clear_inputs();
    at_neg("dual_trap");
    check("dual.cause", 32'(exc_cause), 32'd2);
    check("dual.epc", exc_epc, 32'h0000_2220);
    edge_step();

    // ret redirects like a trap but keeps the cause and raises no exception
    ret = 1'b1; trap_vector = 32'h8000_1234;
    at_neg("ret");
    edge_step();
    ret = 1'b0;
    at_neg("ret_trap");
    check("ret.valid", 32'(exc_valid), 32'd0);
    check("ret.cause", 32'(exc_cause), 32'd2);
    check("ret.priv_pc", priv_pc, 32'h8000_1234);
    edge_step();

    // halt is sticky until reset
    halt = 1'b1;
    at_neg("halt");
    edge_step();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg("halted");
      check($sformatf("halted%0d", i), 32'({iren, pc_en}), 32'd0);
      edge_step();
    end
    nRST = 1'b0;
    at_neg("halt_reset");
    edge_step();
    nRST = 1'b1;
    at_neg("after_reset");
    check("after_reset.cnt", stall_cycles, 32'd0);
    check("after_reset.pc_en", 32'(pc_en), 32'd1);
    edge_step();

    for (int i = 0; i < 400; i++) begin
      nRST = ($urandom_range(0, 99) >= 3);
      f_busy = ($urandom_range(0, 99) < 20);
      x_busy = ($urandom_range(0, 99) < 20);
      m_busy = ($urandom_range(0, 99) < 30);
      dren = ($urandom_range(0, 99) < 30);
      dwen = ($urandom_range(0, 99) < 20);
      fence_stall = ($urandom_range(0, 99) < 5);
      jump = ($urandom_range(0, 99) < 10);
      mispredict = ($urandom_range(0, 99) < 10);
      halt = ($urandom_range(0, 99) < 1);
      ret = ($urandom_range(0, 99) < 2);
      {fault_insn, mal_insn, illegal_insn, fault_ld, mal_ld} = 5'd0;
      {fault_st, mal_st, breakpoint, env_m} = 4'd0;
      fault_insn = ($urandom_range(0, 99) < 1);
      mal_insn = ($urandom_range(0, 99) < 1);
      illegal_insn = ($urandom_range(0, 99) < 1);
      fault_ld = ($urandom_range(0, 99) < 1);
      mal_ld = ($urandom_range(0, 99) < 1);
      fault_st = ($urandom_range(0, 99) < 1);
      mal_st = ($urandom_range(0, 99) < 1);
      breakpoint = ($urandom_range(0, 99) < 1);
      env_m = ($urandom_range(0, 99) < 1);
      epc_f = $urandom; epc_m = $urandom; badaddr_f = $urandom; badaddr_m = $urandom;
      trap_vector = $urandom;
      rs1_x = 5'($urandom_range(0, 7)); rs2_x = 5'($urandom_range(0, 7));
      rd_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
      regWEN_m = ($urandom_range(0, 99) < 60);
      regWEN_w = ($urandom_range(0, 99) < 60);
      at_neg("rnd");
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
